// File: rtl/div_result_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_result_fifo_if : divider-result FIFO producer/consumer bundle    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface div_result_fifo_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         q_in;
  logic                     dvz_in;
  logic                     ovf_in;
  logic                     valid_in;
  logic                     rd_en;
  logic [WIDTH-1:0]         q_out;
  logic                     dvz_out;
  logic                     ovf_out;
  logic                     out_valid;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     drop;
  logic [7:0]               err_count;

  modport master (
    output q_in, dvz_in, ovf_in, valid_in, rd_en,
    input  q_out, dvz_out, ovf_out, out_valid, full, empty, count, drop, err_count
  );

  modport slave (
    input  q_in, dvz_in, ovf_in, valid_in, rd_en,
    output q_out, dvz_out, ovf_out, out_valid, full, empty, count, drop, err_count
  );
endinterface
`default_nettype wire

// File: rtl/div_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_result_fifo : show-ahead FIFO buffering divider results + flags  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input wire               clk,
  input wire               sclr,
  div_result_fifo_if.slave bus
);
  localparam int c_addr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w   = $clog2(DEPTH) + 1;
  localparam int c_entry_w = WIDTH + 2;

  logic [c_entry_w-1:0] mem_q [DEPTH];
  logic [c_addr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_addr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]   count_q, count_d;
  logic                 drop_q, drop_d;
  logic [7:0]           err_count_q, err_count_d;

  logic                 full;
  logic                 empty;
  logic                 wr_accept;
  logic                 rd_accept;
  logic [c_entry_w-1:0] head;

  assign full  = (count_q == c_cnt_w'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a write.
  assign wr_accept = bus.valid_in & (~full | bus.rd_en);
  assign rd_accept = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_count_d = err_count_q;
    drop_d      = bus.valid_in & full & ~bus.rd_en;

    if (wr_accept) wr_ptr_d = wr_ptr_q + c_addr_w'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + c_addr_w'(1);

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase

    if (wr_accept && (bus.dvz_in || bus.ovf_in) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      err_count_q <= err_count_d;
    end
  end

  // Storage has no reset; stale contents are masked while empty.
  always_ff @(posedge clk) begin
    if (!sclr && wr_accept)
      mem_q[wr_ptr_q] <= {bus.q_in, bus.dvz_in, bus.ovf_in};
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.q_out     = empty ? '0   : head[c_entry_w-1:2];
  assign bus.dvz_out   = empty ? 1'b0 : head[1];
  assign bus.ovf_out   = empty ? 1'b0 : head[0];
  assign bus.out_valid = ~empty;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.drop      = drop_q;
  assign bus.err_count = err_count_q;
endmodule
`default_nettype wire

// File: tb/tb_div_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_result_fifo : randomized bench with queue reference model     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_div_result_fifo;
  localparam int WIDTH = 10;
  localparam int DEPTH = 4;
  localparam int VW    = WIDTH + 3 + 3 + 3 + 8;

  logic clk;
  logic sclr;
  int   checks;
  int   errors;

  div_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  div_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of {q, dvz, ovf} plus the side counters.
  logic [WIDTH+1:0] mq [$];
  int               merr;
  bit               mdrop;

  function automatic void model_update();
    bit was_full;
    bit was_empty;
    bit wr;
    bit pop;
    if (sclr) begin
      mq.delete();
      merr  = 0;
      mdrop = 0;
      return;
    end
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    wr    = bus.valid_in && (!was_full || bus.rd_en);
    pop   = bus.rd_en && !was_empty;
    mdrop = bus.valid_in && was_full && !bus.rd_en;
    if (pop) void'(mq.pop_front());
    if (wr) begin
      mq.push_back({bus.q_in, bus.dvz_in, bus.ovf_in});
      if ((bus.dvz_in || bus.ovf_in) && merr < 255) merr++;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [WIDTH+1:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    return {h[WIDTH+1:2], h[1], h[0], (mq.size() != 0), (mq.size() == DEPTH),
            (mq.size() == 0), 3'(mq.size()), mdrop, 8'(merr)};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.q_out, bus.dvz_out, bus.ovf_out, bus.out_valid, bus.full,
            bus.empty, bus.count, bus.drop, bus.err_count};
  endfunction

  task automatic drive(input bit v, input logic [WIDTH-1:0] q, input bit dvz,
                       input bit ovf, input bit rd);
    bus.valid_in = v;
    bus.q_in     = q;
    bus.dvz_in   = dvz;
    bus.ovf_in   = ovf;
    bus.rd_en    = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    idle();
    step();
    sclr = 1'b0;
  endtask

  task automatic test_reset();
    sclr = 1'b1;
    drive(1'b1, 10'h2AA, 1'b1, 1'b1, 1'b1);
    step();
    sclr = 1'b0;
    idle();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.q_out !== 10'd0) begin
      errors++;
      $display("FAIL reset_flags: got empty=%b count=%0d q=%h expected 1/0/000",
               bus.empty, bus.count, bus.q_out);
    end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 10'h005, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    checks++;
    if (bus.count !== 3'd2 || bus.q_out !== 10'h005) begin
      errors++;
      $display("FAIL basic_two_writes: got count=%0d q=%h expected 2/005", bus.count, bus.q_out);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    checks++;
    if (bus.q_out !== 10'h3FF || bus.dvz_out !== 1'b1 || bus.err_count !== 8'd1) begin
      errors++;
      $display("FAIL basic_after_pop: got q=%h dvz=%b err=%0d expected 3ff/1/1",
               bus.q_out, bus.dvz_out, bus.err_count);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL basic_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
      step();
      if (i == 4) begin
        checks++;
        if (bus.full !== 1'b1) begin
          errors++;
          $display("FAIL ovf_full: got full=%b expected 1", bus.full);
        end
      end
      if (i == 5) begin
        checks++;
        if (bus.drop !== 1'b1 || bus.count !== 3'd4) begin
          errors++;
          $display("FAIL ovf_drop: got drop=%b count=%0d expected 1/4", bus.drop, bus.count);
        end
      end
    end
    idle();
    step();
    checks++;
    if (bus.drop !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop_pulse: got drop=%b expected 0", bus.drop);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (bus.q_out !== 10'(i)) begin
        errors++;
        $display("FAIL ovf_order: got q=%h expected %h", bus.q_out, 10'(i));
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step();
      idle();
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained: got empty=%b expected 1", bus.empty);
    end
  endtask

  task automatic test_full_simul();
    logic [WIDTH-1:0] order [4];
    order[0] = 10'd2; order[1] = 10'd3; order[2] = 10'd4; order[3] = 10'h009;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 10'h009, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    checks++;
    if (bus.count !== 3'd4 || bus.drop !== 1'b0 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL full_simul: got count=%0d drop=%b full=%b expected 4/0/1",
               bus.count, bus.drop, bus.full);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.q_out !== order[i]) begin
        errors++;
        $display("FAIL full_simul_order: got q=%h expected %h", bus.q_out, order[i]);
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step();
      idle();
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (bus.count !== 3'd0 || bus.q_out !== 10'd0 || bus.out_valid !== 1'b0 ||
          obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL empty_read: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    drive(1'b1, 10'h123, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.q_out !== 10'd0) begin
      errors++;
      $display("FAIL no_fall_through: got valid=%b q=%h expected 0/000", bus.out_valid, bus.q_out);
    end
    step();
    idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.q_out !== 10'h123 || bus.ovf_out !== 1'b1) begin
      errors++;
      $display("FAIL empty_then_write: got valid=%b q=%h ovf=%b expected 1/123/1",
               bus.out_valid, bus.q_out, bus.ovf_out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 300; i++) begin
      drive(i < 300, 10'($urandom), 1'b0, 1'b1, i > 0);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    idle();
    checks++;
    if (bus.err_count !== 8'd255 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_err_sat: got err=%0d empty=%b expected 255/1", bus.err_count, bus.empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'($urandom), 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 10'h155, 1'b1, 1'b1, 1'b0);
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    idle();
    checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.q_out !== 10'd0 ||
        bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: got count=%0d empty=%b q=%h err=%0d expected 0/1/000/0",
               bus.count, bus.empty, bus.q_out, bus.err_count);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      // Alternate fill-biased and drain-biased phases to visit full and empty.
      bit fill_phase;
      fill_phase = ((i / 40) % 2) == 0;
      sclr = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) != (fill_phase ? 0 : 1) && (fill_phase || $urandom_range(0, 1) == 0),
            10'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    sclr = 1'b0;
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    merr   = 0;
    mdrop  = 0;
    sclr   = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_empty_read();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
